// File: rtl/sgmii_link_pkg.sv
// sgmii_link_pkg: shared states, status_vector bit positions and speed codes for the SGMII link manager.
package sgmii_link_pkg;
    typedef enum logic [1:0] {ST_RESTART, ST_AN_WAIT, ST_LINK_UP, ST_LINK_DOWN} state_e;
    localparam int SV_LINK     = 0;
    localparam int SV_SYNC     = 1;
    localparam int SV_SPEED_LO = 10;
    localparam int SV_SPEED_HI = 11;
    localparam int SV_DUPLEX   = 12;
    localparam logic [1:0] SPEED_10   = 2'b00;
    localparam logic [1:0] SPEED_100  = 2'b01;
    localparam logic [1:0] SPEED_1G   = 2'b10;
    localparam logic [1:0] SPEED_RSVD = 2'b11;
    localparam logic [4:0] CFG_VECTOR_AN = 5'b10000;
endpackage

// File: rtl/sgmii_link_ctrl_if.sv
// sgmii_link_ctrl_if: PCS/PMA control/status and MAC gating signals of the SGMII link manager.
interface sgmii_link_ctrl_if;
    logic [15:0] status_vector;
    logic        an_interrupt;
    logic        force_restart;
    logic [4:0]  configuration_vector;
    logic        an_restart_config;
    logic        speed_is_10_100;
    logic        speed_is_100;
    logic        mac_enable;
    logic        link_up;
    logic [1:0]  link_speed;
    logic        link_event;
    logic [15:0] link_up_count;
    logic [15:0] an_timeout_count;
    modport master (
        input  status_vector, an_interrupt, force_restart,
        output configuration_vector, an_restart_config, speed_is_10_100, speed_is_100,
               mac_enable, link_up, link_speed, link_event, link_up_count, an_timeout_count
    );
    modport slave (
        output status_vector, an_interrupt, force_restart,
        input  configuration_vector, an_restart_config, speed_is_10_100, speed_is_100,
               mac_enable, link_up, link_speed, link_event, link_up_count, an_timeout_count
    );
endinterface

// File: rtl/sgmii_link_debounce.sv
// sgmii_link_debounce: reports when i_in has been seen unchanged for CYCLES consecutive edges.
module sgmii_link_debounce #(
    parameter int CYCLES = 1250
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_in,
    input  logic i_clear,
    output logic o_stable,
    output logic o_value
);
    localparam int W = $clog2(CYCLES + 1);
    logic [W-1:0] r_cnt;
    logic         r_prev;
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_cnt  <= '0;
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_in;
            if (i_clear || i_in != r_prev) r_cnt <= '0;
            else if (r_cnt != W'(CYCLES - 1)) r_cnt <= r_cnt + 1'b1;
        end
    end
    assign o_stable = r_cnt == W'(CYCLES - 1);
    assign o_value  = r_prev;
endmodule

// File: rtl/sgmii_link_ctrl.sv
// sgmii_link_ctrl: auto-negotiation sequencer, link debounce and MAC gating for the SGMII path.
// Define SGMII_LINK_STATS_EN to build the link-up / AN-timeout statistics counters.
module sgmii_link_ctrl
    import sgmii_link_pkg::*;
#(
    parameter int AN_TIMEOUT_CYCLES    = 12500000,
    parameter int DEBOUNCE_CYCLES      = 1250,
    parameter int RESTART_PULSE_CYCLES = 4
) (
    input logic i_clock,
    input logic i_reset,
    sgmii_link_ctrl_if.master io_link
);
    localparam int TW = $clog2(AN_TIMEOUT_CYCLES + 1);
    localparam int PW = $clog2(RESTART_PULSE_CYCLES + 1);
    state_e        r_state, w_next;
    logic [TW-1:0] r_tcnt;
    logic [PW-1:0] r_pcnt;
    logic [1:0]    r_speed, w_sv_speed;
    logic r_an_int_d, r_restart, r_link_up, r_event, r_s10_100, r_s100;
    logic w_good, w_good_stable, w_good_val, w_spd_stable, w_spd_val, w_an_rise, w_enter_up;
    logic w_unused;
    assign w_sv_speed = io_link.status_vector[SV_SPEED_HI:SV_SPEED_LO];
    assign w_good     = io_link.status_vector[SV_LINK] & io_link.status_vector[SV_SYNC]
                      & (w_sv_speed != SPEED_RSVD) & io_link.status_vector[SV_DUPLEX];
    assign w_an_rise  = io_link.an_interrupt & ~r_an_int_d;
    assign w_enter_up = w_next == ST_LINK_UP && r_state != ST_LINK_UP;
    assign w_unused   = ^{io_link.status_vector[15:13], io_link.status_vector[9:2]};
    sgmii_link_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_good_db (
        .i_clock(i_clock), .i_reset(i_reset), .i_in(w_good), .i_clear(r_state == ST_RESTART),
        .o_stable(w_good_stable), .o_value(w_good_val)
    );
    sgmii_link_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_speed_db (
        .i_clock(i_clock), .i_reset(i_reset), .i_in(w_sv_speed != r_speed),
        .i_clear(r_state != ST_LINK_UP), .o_stable(w_spd_stable), .o_value(w_spd_val)
    );
    // The pulse counter only advances once the restart output is high, so a reset
    // exit and a re-entry both give exactly RESTART_PULSE_CYCLES of pulse.
    always_comb begin
        w_next = r_state;
        if (io_link.force_restart) w_next = ST_RESTART;
        else case (r_state)
            ST_RESTART: w_next = (r_restart && r_pcnt == PW'(RESTART_PULSE_CYCLES - 1)) ? ST_AN_WAIT : ST_RESTART;
            ST_AN_WAIT: w_next = (w_good_stable && w_good_val) ? ST_LINK_UP :
                                 (r_tcnt == TW'(AN_TIMEOUT_CYCLES) && !w_an_rise) ? ST_RESTART : ST_AN_WAIT;
            ST_LINK_UP: w_next = ((w_good_stable && !w_good_val) || (w_spd_stable && w_spd_val)) ? ST_LINK_DOWN : ST_LINK_UP;
            default:    w_next = ST_RESTART;
        endcase
    end
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= ST_RESTART;
            r_pcnt     <= '0;
            r_tcnt     <= '0;
            r_an_int_d <= 1'b0;
            r_restart  <= 1'b0;
            r_link_up  <= 1'b0;
            r_event    <= 1'b0;
            r_speed    <= SPEED_1G;
            r_s10_100  <= 1'b0;
            r_s100     <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_an_int_d <= io_link.an_interrupt;
            r_pcnt     <= (r_state == ST_RESTART && w_next == ST_RESTART && r_restart && !io_link.force_restart) ? r_pcnt + 1'b1 : '0;
            r_tcnt     <= (r_state == ST_AN_WAIT && w_next == ST_AN_WAIT && !w_an_rise) ? r_tcnt + 1'b1 : '0;
            r_restart  <= w_next == ST_RESTART;
            r_link_up  <= r_state == ST_LINK_UP && w_next == ST_LINK_UP;
            r_event    <= (r_state == ST_LINK_UP && w_next == ST_LINK_UP) != r_link_up;
            if (w_enter_up) begin
                r_speed   <= w_sv_speed;
                r_s10_100 <= w_sv_speed != SPEED_1G;
                r_s100    <= w_sv_speed == SPEED_100;
            end
        end
    end
    assign io_link.configuration_vector = CFG_VECTOR_AN;
    assign io_link.an_restart_config    = r_restart;
    assign io_link.mac_enable           = r_link_up;
    assign io_link.link_up              = r_link_up;
    assign io_link.link_event           = r_event;
    assign io_link.link_speed           = r_speed;
    assign io_link.speed_is_10_100      = r_s10_100;
    assign io_link.speed_is_100         = r_s100;
`ifdef SGMII_LINK_STATS_EN
    logic [15:0] r_up_cnt, r_to_cnt;
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_up_cnt <= '0;
            r_to_cnt <= '0;
        end else begin
            if (w_enter_up && r_up_cnt != 16'hFFFF) r_up_cnt <= r_up_cnt + 1'b1;
            if (r_state == ST_AN_WAIT && w_next == ST_RESTART && !io_link.force_restart && r_to_cnt != 16'hFFFF)
                r_to_cnt <= r_to_cnt + 1'b1;
        end
    end
    assign io_link.link_up_count    = r_up_cnt;
    assign io_link.an_timeout_count = r_to_cnt;
`else
    assign io_link.link_up_count    = '0;
    assign io_link.an_timeout_count = '0;
`endif
endmodule

// File: tb/tb_sgmii_link_ctrl.sv
// tb_sgmii_link_ctrl: directed bench for the SGMII link manager (AN timeout 1500, debounce 1250, pulse 4).
module tb_sgmii_link_ctrl;
    localparam int T = 1500;
    localparam int D = 1250;
`ifdef SGMII_LINK_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    typedef struct {
        logic [15:0] sv;
        logic        up;
        logic [1:0]  spd;
        logic        s10_100;
        logic        s100;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    vec_t tbl [5];
    always #4 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    sgmii_link_ctrl_if bus ();
    sgmii_link_ctrl #(
        .AN_TIMEOUT_CYCLES(T), .DEBOUNCE_CYCLES(D), .RESTART_PULSE_CYCLES(4)
    ) dut (
        .i_clock(clk), .i_reset(rst), .io_link(bus)
    );
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic wait_link(input logic level, input int bound, output int n);
        n = 0;
        while (bus.link_up !== level && n < bound) begin
            tick(1);
            n++;
        end
    endtask
    task automatic wait_rise(output int at);
        logic p;
        p  = bus.an_restart_config;
        at = -1;
        for (int n = 0; n < 3000 && at < 0; n++) begin
            tick(1);
            if (!p && bus.an_restart_config) at = cyc;
            p = bus.an_restart_config;
        end
    endtask
    task automatic pulse_force();
        bus.force_restart = 1'b1;
        tick(1);
        bus.force_restart = 1'b0;
    endtask
    initial begin
        int n, c0, r1, r2, r3, r4, bad, up_cnt;
        tbl[0] = '{16'h1403, 1'b1, 2'b01, 1'b1, 1'b1};
        tbl[1] = '{16'h1003, 1'b1, 2'b00, 1'b1, 1'b0};
        tbl[2] = '{16'h1C03, 1'b0, 2'b00, 1'b1, 1'b0};
        tbl[3] = '{16'h0803, 1'b0, 2'b00, 1'b1, 1'b0};
        tbl[4] = '{16'h1803, 1'b1, 2'b10, 1'b0, 1'b0};
        bus.status_vector = 16'h1803;
        bus.an_interrupt  = 1'b0;
        bus.force_restart = 1'b0;
        tick(3);
        check("rst_restart", bus.an_restart_config, 0);
        check("rst_mac", bus.mac_enable, 0);
        check("rst_up", bus.link_up, 0);
        check("rst_speed", bus.link_speed, 2'b10);
        check("rst_event", bus.link_event, 0);
        check("rst_cfg", bus.configuration_vector, 5'b10000);
        check("rst_upcnt", bus.link_up_count, 0);
        check("rst_tocnt", bus.an_timeout_count, 0);
        rst = 1'b0;
        c0 = cyc;
        for (int i = 1; i <= 6; i++) begin
            tick(1);
            check($sformatf("restart_pulse_%0d", i), bus.an_restart_config, i <= 4);
        end
        wait_link(1'b1, 2000, n);
        check("up_after_an_entry", cyc - (c0 + 5), D + 1);
        check("up_event", bus.link_event, 1);
        check("up_mac", bus.mac_enable, 1);
        check("up_s10_100", bus.speed_is_10_100, 0);
        check("up_s100", bus.speed_is_100, 0);
        check("up_speed", bus.link_speed, 2'b10);
        check("up_count1", bus.link_up_count, STATS ? 1 : 0);
        up_cnt = 1;
        bad = 0;
        bus.status_vector = 16'h1802;
        for (int i = 0; i < 2300; i++) begin
            if (i == 1000) bus.status_vector = 16'h1803;
            tick(1);
            if (bus.link_event || !bus.mac_enable) bad++;
        end
        check("glitch_no_drop", bad, 0);
        bus.status_vector = 16'h1802;
        wait_link(1'b0, 2000, n);
        check("down_latency", n, D + 1);
        check("down_mac", bus.mac_enable, 0);
        check("down_event", bus.link_event, 1);
        check("down_restart_lo", bus.an_restart_config, 0);
        tick(1);
        check("down_restart_hi", bus.an_restart_config, 1);
        check("down_event_clr", bus.link_event, 0);
        r1 = cyc;
        wait_rise(r2);
        wait_rise(r3);
        check("timeout_period1", r2 - r1, T + 5);
        check("timeout_period2", r3 - r2, T + 5);
        check("timeout_count2", bus.an_timeout_count, STATS ? 2 : 0);
        tick(500);
        bus.an_interrupt = 1'b1;
        c0 = cyc;
        tick(1);
        bus.an_interrupt = 1'b0;
        wait_rise(r4);
        check("an_int_extends", r4 - c0, T + 2);
        check("timeout_count3", bus.an_timeout_count, STATS ? 3 : 0);
        for (int i = 0; i < 5; i++) begin
            bus.status_vector = tbl[i].sv;
            pulse_force();
            wait_link(1'b1, 1300, n);
            if (tbl[i].up) begin
                check($sformatf("tbl%0d_latency", i), n, D + 5);
                up_cnt++;
            end
            check($sformatf("tbl%0d_up", i), bus.link_up, tbl[i].up);
            check($sformatf("tbl%0d_speed", i), bus.link_speed, tbl[i].spd);
            check($sformatf("tbl%0d_s10_100", i), bus.speed_is_10_100, tbl[i].s10_100);
            check($sformatf("tbl%0d_s100", i), bus.speed_is_100, tbl[i].s100);
        end
        check("tbl_upcnt", bus.link_up_count, STATS ? up_cnt : 0);
        bus.status_vector = 16'h1403;
        wait_link(1'b0, 2000, n);
        check("spdchg_down", n, D + 1);
        wait_link(1'b1, 2000, n);
        check("spdchg_reup", n, D + 6);
        check("spdchg_speed", bus.link_speed, 2'b01);
        check("spdchg_s10_100", bus.speed_is_10_100, 1);
        check("spdchg_s100", bus.speed_is_100, 1);
        up_cnt++;
        check("spdchg_upcnt", bus.link_up_count, STATS ? up_cnt : 0);
        pulse_force();
        tick(D + 2);
        bus.force_restart = 1'b1;
        tick(1);
        bus.force_restart = 1'b0;
        check("race_restart", bus.an_restart_config, 1);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (bus.link_up || bus.link_event) bad++;
        end
        check("race_no_up", bad, 0);
        check("race_upcnt", bus.link_up_count, STATS ? up_cnt : 0);
        wait_link(1'b1, 1400, n);
        check("race_reup", bus.link_up, 1);
        rst = 1'b1;
        tick(1);
        check("mid_rst_up", bus.link_up, 0);
        check("mid_rst_mac", bus.mac_enable, 0);
        check("mid_rst_event", bus.link_event, 0);
        check("mid_rst_restart", bus.an_restart_config, 0);
        check("mid_rst_speed", bus.link_speed, 2'b10);
        check("mid_rst_s10_100", bus.speed_is_10_100, 0);
        check("mid_rst_s100", bus.speed_is_100, 0);
        check("mid_rst_upcnt", bus.link_up_count, 0);
        check("mid_rst_tocnt", bus.an_timeout_count, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
